// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the EX mul/div controller.
// MULDIV_DIVZERO_FAST_EN (in muldiv_ctrl) short-circuits divide-by-zero.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_SEND,
    S_DIV_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam int OP_MUL   = 0;
  localparam int OP_MULH  = 1;
  localparam int OP_MULHU = 2;
  localparam int OP_DIV   = 3;
  localparam int OP_MOD   = 4;
  localparam int OP_DIVU  = 5;
  localparam int OP_MODU  = 6;

  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 2;

  localparam logic [31:0] DIVZERO_QUOT = 32'hffff_ffff;

  function automatic logic onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/muldiv_mul_pipe.sv
// muldiv_mul_pipe: 33x33 signed multiplier, STAGES result registers,
// with a stage-valid chain that a flush clears.
module muldiv_mul_pipe
  import muldiv_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start,
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic        done,
  output logic [63:0] prod
);

  localparam int N =
    (STAGES < MUL_STAGES_MIN) ? MUL_STAGES_MIN :
    (STAGES > MUL_STAGES_MAX) ? MUL_STAGES_MAX :
    STAGES;

  logic signed [63:0] full;
  logic [63:0]        p_q [N];
  logic [N-1:0]       v_q;

  // Low 64 bits of the 66-bit product are all any op needs
  assign full = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < N; i++) p_q[i] <= '0;
    end else begin
      v_q[0] <= start & ~flush;
      p_q[0] <= full;
      for (int i = 1; i < N; i++) begin
        v_q[i] <= v_q[i-1] & ~flush;
        p_q[i] <= p_q[i-1];
      end
    end
  end

  assign done = v_q[N-1];
  assign prod = p_q[N-1];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences mul/div ops onto the multiplier and divider IPs.
// Define MULDIV_DIVZERO_FAST_EN to bypass the dividers on a zero divisor.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [6:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        res_ready,
  output logic        op_ready,
  output logic        res_valid,
  output logic [31:0] res,
  output logic        busy,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        sdiv_tvalid,
  output logic        udiv_tvalid,
  input  logic        sdiv_tready,
  input  logic        udiv_tready,
  input  logic        sdiv_dout_tvalid,
  input  logic        udiv_dout_tvalid,
  input  logic [63:0] sdiv_dout,
  input  logic [63:0] udiv_dout
);

  state_t      state, state_n, acc_state;
  logic [6:0]  op_q;
  logic [31:0] res_n, dz_res;
  logic        accept, ld_res, fast_dz;
  logic        is_mul, is_div, sgn_in, mod_in;
  logic        sgn_q, mod_q, sgn_n;
  logic        tready, dvalid, mul_done;
  logic [63:0] dout, mul_prod;
  logic [32:0] mul_a, mul_b;

  assign accept = op_valid & |op & ~flush &
                  ((state == S_IDLE) |
                   ((state == S_DONE) & res_ready));
  assign op_ready  = accept;
  assign res_valid = (state == S_DONE);

  assign is_mul = |op[OP_MULHU:OP_MUL];
  assign is_div = |op[OP_MODU:OP_DIV];
  assign sgn_in = op[OP_DIV] | op[OP_MOD];
  assign mod_in = op[OP_MOD] | op[OP_MODU];
  assign sgn_q  = op_q[OP_DIV] | op_q[OP_MOD];
  assign mod_q  = op_q[OP_MOD] | op_q[OP_MODU];

  assign tready = sgn_q ? sdiv_tready : udiv_tready;
  assign dvalid = sgn_q ? sdiv_dout_tvalid
                        : udiv_dout_tvalid;
  assign dout   = sgn_q ? sdiv_dout : udiv_dout;

  assign mul_a = {~op[OP_MULHU] & src1[31], src1};
  assign mul_b = {~op[OP_MULHU] & src2[31], src2};

`ifdef MULDIV_DIVZERO_FAST_EN
  assign fast_dz = is_div & (src2 == 32'd0);
`else
  assign fast_dz = 1'b0;
`endif
  assign dz_res = mod_in ? src1 : DIVZERO_QUOT;

  muldiv_mul_pipe #(
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk   (clk),
    .rst_n (resetn),
    .flush (flush),
    .start (accept & onehot7(op) & is_mul),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    acc_state = S_IDLE;
    if (onehot7(op)) begin
      unique case (1'b1)
        is_mul:  acc_state = S_MUL;
        is_div:  acc_state = fast_dz ? S_DONE
                                     : S_DIV_SEND;
        default: acc_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    ld_res  = 1'b0;
    res_n   = dz_res;
    if (flush) begin
      unique case (state)
        S_DIV_SEND: state_n = tready ? S_DRAIN : S_IDLE;
        S_DIV_WAIT: state_n = S_DRAIN;
        S_DRAIN:    state_n = dvalid ? S_IDLE : S_DRAIN;
        default:    state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && state != S_DRAIN &&
                 !onehot7(op_q)) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          state_n = acc_state;
          ld_res  = fast_dz;
        end
        S_MUL: if (mul_done) begin
          state_n = S_DONE;
          ld_res  = 1'b1;
          res_n   = op_q[OP_MUL] ? mul_prod[31:0]
                                 : mul_prod[63:32];
        end
        S_DIV_SEND: if (tready) state_n = S_DIV_WAIT;
        S_DIV_WAIT: if (dvalid) begin
          state_n = S_DONE;
          ld_res  = 1'b1;
          res_n   = mod_q ? dout[31:0] : dout[63:32];
        end
        S_DONE: if (accept) begin
          state_n = acc_state;
          ld_res  = fast_dz;
        end else if (res_ready) begin
          state_n = S_IDLE;
        end
        S_DRAIN: if (dvalid) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Divider select follows the incoming op on accept, the latched one after
  assign sgn_n = accept ? sgn_in : sgn_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      op_q        <= '0;
      div_a       <= '0;
      div_b       <= '0;
      res         <= '0;
      busy        <= 1'b0;
      sdiv_tvalid <= 1'b0;
      udiv_tvalid <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op;
        div_a <= src1;
        div_b <= src2;
      end
      if (ld_res) res <= res_n;
      busy        <= (state_n != S_IDLE);
      sdiv_tvalid <= (state_n == S_DIV_SEND) & sgn_n;
      udiv_tvalid <= (state_n == S_DIV_SEND) & ~sgn_n;
    end
  end

endmodule
